// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   STALL_* : stall vector patterns, bit i stalls stage i
//             ([0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB)
//   ST_*    : FSM state encodings
package pipe_stall_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_HALT = 6'b111111;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_AES_WAIT = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_ERROR    = 2'd3;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the core pipeline and the stall sequencer.
//   master : pipeline side, drives hazard/request inputs, receives stall/flush
//   slave  : sequencer side
interface pipe_stall_ctrl_if;
    logic       id_stallreq;
    logic       ex_branch_flush;
    logic       ex_aes_req;
    logic       aes_done;
    logic       me_mem_req;
    logic       mem_ack;
    logic [5:0] stall;
    logic       flush;
    logic       aes_start;
    logic       mem_err;
    logic       ctrl_busy;

    modport master (
        output id_stallreq, ex_branch_flush, ex_aes_req, aes_done, me_mem_req, mem_ack,
        input  stall, flush, aes_start, mem_err, ctrl_busy
    );

    modport slave (
        input  id_stallreq, ex_branch_flush, ex_aes_req, aes_done, me_mem_req, mem_ack,
        output stall, flush, aes_start, mem_err, ctrl_busy
    );
endinterface

// File: rtl/pipe_stall_ctrl_mem_wait_timer.sv
// Wait-cycle counter for data-memory accesses.
//   clk, rst : core clock, synchronous active-high reset
//   clr      : clear counter (exit from a memory wait); wins over en
//   en       : count one more wait cycle (saturates, never wraps)
//   timeout  : counter has reached MEM_TIMEOUT
module pipe_stall_ctrl_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam logic [TMR_W-1:0] CNT_MAX     = '1;
    localparam logic [TMR_W-1:0] TIMEOUT_VAL = TMR_W'(MEM_TIMEOUT);

    logic [TMR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && count != CNT_MAX)
            count <= count + 1'b1;
    end

    assign timeout = (count == TIMEOUT_VAL);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage core with AES coprocessor.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : slave side of pipe_stall_ctrl_if
//              in : id_stallreq, ex_branch_flush, ex_aes_req, aes_done,
//                   me_mem_req, mem_ack
//              out: stall[5:0], flush, aes_start, mem_err (sticky), ctrl_busy
// Outputs are Mealy: decoded from the current state and current inputs, so
// every stall takes effect in the cycle of the request and every release in
// the cycle of the ack/done.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    pipe_stall_ctrl_if.slave    bus
);

    logic [1:0] state, state_d;
    logic       done_q, done_d;
    logic       mem_err_q;
    logic [5:0] stall_c;
    logic       flush_c, start_c;
    logic       tmr_clr, tmr_en, timeout;
    logic       mem_pend;

    assign mem_pend = bus.me_mem_req && !bus.mem_ack;

    pipe_stall_ctrl_mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .timeout (timeout)
    );

    always_comb begin
        state_d = state;
        done_d  = done_q;
        stall_c = STALL_NONE;
        flush_c = 1'b0;
        start_c = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state)
            ST_RUN: begin
                // Counter is 0 here, so enabling it loads the first wait cycle.
                if (mem_pend) begin
                    stall_c = STALL_MEM;
                    tmr_en  = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else if (bus.ex_aes_req) begin
                    start_c = 1'b1;
                    stall_c = STALL_EX;
                    state_d = ST_AES_WAIT;
                end else if (bus.ex_branch_flush) begin
                    // Any ID hazard belongs to the wrong path; drop it.
                    flush_c = 1'b1;
                end else if (bus.id_stallreq) begin
                    stall_c = STALL_ID;
                end
            end
            ST_MEM_WAIT: begin
                stall_c = STALL_MEM;
                if (bus.mem_ack) begin
                    // Ack beats a simultaneous timeout.
                    stall_c = STALL_NONE;
                    tmr_clr = 1'b1;
                    state_d = ST_RUN;
                end else if (timeout) begin
                    state_d = ST_ERROR;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_AES_WAIT: begin
                done_d = done_q | bus.aes_done;
                if (mem_pend) begin
                    // Older memory op still waiting: hold MEM, keep the done latched.
                    stall_c = STALL_MEM;
                    if (timeout) begin
                        state_d = ST_ERROR;
                        done_d  = 1'b0;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end else begin
                    tmr_clr = 1'b1;
                    if (bus.aes_done || done_q) begin
                        done_d  = 1'b0;
                        state_d = ST_RUN;
                    end else begin
                        stall_c = STALL_EX;
                    end
                end
            end
            default: begin
                stall_c = STALL_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            done_q    <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state  <= state_d;
            done_q <= done_d;
            if (state_d == ST_ERROR)
                mem_err_q <= 1'b1;
        end
    end

    assign bus.stall     = rst ? STALL_NONE : stall_c;
    assign bus.flush     = rst ? 1'b0 : flush_c;
    assign bus.aes_start = rst ? 1'b0 : start_c;
    assign bus.mem_err   = mem_err_q;
    assign bus.ctrl_busy = (state != ST_RUN);

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32I core with AES coprocessor. It produces the 6-bit stall vector consumed by every pipeline register (PC/IF_ID/ID_EX/EX_ME/ME_WB) and the branch flush. A small FSM handles multi-cycle data-memory waits, the AES coprocessor start/done handshake and a fatal memory-timeout halt. Stall bit mapping: [0]=PC, [1]=IF, [2]=ID, [3]=EX, [4]=MEM, [5]=WB. A pipeline register between stage i and i+1 bubbles when stall[i] && !stall[i+1].

Parameters:
MEM_TIMEOUT, 15, wait cycles without mem_ack before fatal error (1..2^TMR_W-1)
TMR_W, 4, width of wait-cycle counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
id_stallreq  in  1  load-use hazard detected in ID (combinational, per cycle)
ex_branch_flush  in  1  taken branch/jump resolved in EX
ex_aes_req  in  1  AES custom instruction present in EX
aes_done  in  1  AES coprocessor result ready (1-cycle pulse)
me_mem_req  in  1  MEM stage performing load/store
mem_ack  in  1  data memory access complete this cycle
stall  out  6  stall vector to pipeline registers
flush  out  1  kill IF_ID/ID_EX contents, redirect PC
aes_start  out  1  1-cycle start pulse to AES coprocessor
mem_err  out  1  sticky memory-timeout error
ctrl_busy  out  1  FSM not in RUN

Behaviour:
- Stall patterns: NONE=6'b000000, ID=6'b000111, EX=6'b001111, MEM=6'b011111, HALT=6'b111111.
- States: RUN, AES_WAIT, MEM_WAIT, ERROR. Outputs are Mealy: combinational from the state and the current inputs. State, counter and done_q are registered.
- Reset (rst=1 at a clock edge): state=RUN, counter=0, done_q=0, mem_err=0. While rst is high, stall, flush and aes_start are forced to 0 regardless of inputs.
- RUN, evaluated in priority order:
  - me_mem_req && !mem_ack: stall=MEM, counter<=1, go to MEM_WAIT. EX-level requests are ignored this cycle and are re-seen once the pipeline resumes.
  - ex_aes_req: aes_start=1, stall=EX, go to AES_WAIT.
  - ex_branch_flush: flush=1, stall=NONE. id_stallreq is ignored because it belongs to a wrong-path instruction.
  - id_stallreq: stall=ID.
  - Otherwise: stall=NONE.
- MEM_WAIT:
  - mem_ack=1: stall=NONE, counter<=0, go to RUN.
  - Otherwise: stall=MEM, counter++.
  - When counter==MEM_TIMEOUT with no ack: go to ERROR, mem_err<=1.
- AES_WAIT:
  - aes_done is captured into done_q (set on the pulse, cleared on exit).
  - If me_mem_req && !mem_ack: stall=MEM that cycle and the counter runs. The timeout rules of MEM_WAIT apply. The state stays AES_WAIT.
  - Else if aes_done || done_q: stall=NONE, go to RUN, done_q<=0.
  - Else: stall=EX, so instructions ahead of EX drain normally.
  - aes_start is never re-asserted while in AES_WAIT.
  - flush cannot occur here because EX is held. ex_branch_flush is ignored.
- ERROR: stall=HALT, flush=0, aes_start=0, mem_err=1. Only rst exits this state.
- ctrl_busy = (state != RUN).
- Counter: saturates and never wraps. It is cleared on every exit from memory wait.
- Simultaneous mem_ack and timeout boundary: the ack wins and no error is raised.
- aes_done arriving in RUN (spurious): ignored and not latched.
- Latency: every stall/flush decision is effective in the same cycle as the causing request. The release is effective in the same cycle as ack/done.

Decomposition:
- Shared package (Defines.v-style include): the stall pattern constants STALL_NONE/ID/EX/MEM/HALT and the FSM state encodings.
- Natural sub-module: mem_wait_timer, containing the counter, saturate logic and timeout compare. It takes clear/enable inputs and produces a timeout output.
- The FSM and output decode remain in pipe_stall_ctrl.

Test Plan:
1. id_stallreq=1 for one cycle in RUN -> stall=6'b000111 that cycle, then 6'b000000, flush=0.
2. ex_branch_flush=1 and id_stallreq=1 in the same cycle -> flush=1, stall=6'b000000.
3. me_mem_req=1 with mem_ack arriving on the 4th cycle -> stall=6'b011111 for 3 cycles, 6'b000000 on the ack cycle, ctrl_busy high for 3 cycles.
4. ex_aes_req=1, aes_done 10 cycles later -> single aes_start pulse, stall=6'b001111 for 10 cycles, 6'b000000 on the done cycle. Repeat with a 2-cycle memory wait overlapping aes_done: stall=6'b011111 during the wait, release on the first cycle with no memory wait.
5. me_mem_req=1 with no mem_ack for 15 cycles -> mem_err=1, stall=6'b111111 persisting for more than 20 further cycles until rst.
6. rst=1 while in AES_WAIT with done_q set -> after the edge: stall=0, aes_start=0, ctrl_busy=0, and a new ex_aes_req produces a fresh aes_start.
